// File: rtl/demux_lane_packer_pkg.sv
// Shared types and default widths for the demux/lane-packer and downstream mapper stages.
package zb_demux_pkg;

    typedef enum logic {
        MODE_ADDR = 1'b0,
        MODE_SEQ  = 1'b1
    } demux_mode_t;

    localparam int DEMUX_DATA_W = 4;
    localparam int DEMUX_N_CH   = 4;

endpackage

// File: rtl/demux_1n.sv
// Combinational slot-select decoder: one-hot write enables plus an out-of-range flag.
module demux_1n
    import zb_demux_pkg::*;
#(
    parameter int N_CH  = DEMUX_N_CH,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    output logic [N_CH-1:0]  onehot_o,
    output logic             outOfRange_o
);

    // An out-of-range select produces no enable at all, so nothing gets written.
    always_comb begin
        onehot_o     = '0;
        outOfRange_o = (int'(sel_i) >= N_CH);
        for (int k = 0; k < N_CH; k++) begin
            if (en_i && (int'(sel_i) == k)) begin
                onehot_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_lane_packer.sv
// Registered 1:N lane packer: fills N_CH slots from a word stream, emits packed frames with
// valid/ready backpressure through a single output buffer.
module demux_lane_packer
    import zb_demux_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W,
    parameter int N_CH   = DEMUX_N_CH,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                     inClock,
    input  logic                     inReset,
    input  logic [DATA_W-1:0]        inData,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [SEL_W-1:0]         inSel,
    input  logic                     inMode,
    input  logic                     inFlush,
    output logic [DATA_W*N_CH-1:0]   outData,
    output logic [N_CH-1:0]          outMask,
    output logic                     outValid,
    input  logic                     outReady,
    output logic                     outErr
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);

    demux_mode_t             modeNow, mode_q;
    logic [DATA_W-1:0]       acc_q [N_CH];
    logic [DATA_W-1:0]       acc_d [N_CH];
    logic [DATA_W-1:0]       accNext [N_CH];
    logic [N_CH-1:0]         fill_q, fill_d, fillBase, fillNext;
    logic [SEL_W-1:0]        wptr_q, wptr_d, wptrBase, wptrNext, slotSel;
    logic [N_CH-1:0]         wrEn;
    logic                    selOor, accept, discard, complete, flushGo, emit;
    logic [DATA_W*N_CH-1:0]  frameData, outData_q, outData_d;
    logic [N_CH-1:0]         frameMask, outMask_q, outMask_d;
    logic                    outValid_q, outValid_d, err_q, err_d;

    // A mode switch with a partial frame pending throws that frame away before this cycle's word.
    always_comb begin
        modeNow  = demux_mode_t'(inMode);
        inReady  = !inReset && (!outValid_q || outReady);
        accept   = inValid && inReady;
        discard  = (modeNow != mode_q) && (fill_q != '0);
        fillBase = discard ? '0 : fill_q;
        wptrBase = discard ? '0 : wptr_q;
        slotSel  = (modeNow == MODE_SEQ) ? wptrBase : inSel;
    end

    demux_1n #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_demux (
        .sel_i        (slotSel),
        .en_i         (accept),
        .onehot_o     (wrEn),
        .outOfRange_o (selOor)
    );

    always_comb begin
        fillNext = fillBase | wrEn;
        for (int k = 0; k < N_CH; k++) begin
            accNext[k] = wrEn[k] ? inData : (discard ? '0 : acc_q[k]);
        end
        complete = (wrEn != '0) && (&fillNext);
        flushGo  = inFlush && inReady && (fillNext != '0);
        emit     = complete || flushGo;
        err_d    = accept && (modeNow == MODE_ADDR) && selOor;

        wptrNext = wptrBase;
        if ((modeNow == MODE_SEQ) && (wrEn != '0)) begin
            wptrNext = (wptrBase == LAST_SLOT) ? '0 : wptrBase + SEL_W'(1);
        end

        // Slot 0 lands in the MSBs; unfilled slots read as zero.
        frameData = '0;
        frameMask = '0;
        for (int k = 0; k < N_CH; k++) begin
            frameData[(N_CH-1-k)*DATA_W +: DATA_W] = fillNext[k] ? accNext[k] : '0;
            frameMask[N_CH-1-k]                     = fillNext[k];
        end

        outValid_d = outValid_q && !outReady;
        outData_d  = outData_q;
        outMask_d  = outMask_q;
        fill_d     = fillNext;
        wptr_d     = wptrNext;
        acc_d      = accNext;
        if (emit) begin
            outValid_d = 1'b1;
            outData_d  = frameData;
            outMask_d  = frameMask;
            fill_d     = '0;
            wptr_d     = '0;
            acc_d      = '{default: '0};
        end
    end

    always_ff @(posedge inClock) begin
        if (inReset) begin
            mode_q     <= MODE_ADDR;
            acc_q      <= '{default: '0};
            fill_q     <= '0;
            wptr_q     <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outMask_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            mode_q     <= modeNow;
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            wptr_q     <= wptr_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outMask_q  <= outMask_d;
            err_q      <= err_d;
        end
    end

    assign outData  = outData_q;
    assign outMask  = outMask_q;
    assign outValid = outValid_q;
    assign outErr   = err_q;

endmodule
